// File: rtl/lll_pkg.sv
// Shared types, limits and helpers for the lll write responder.
package lll_pkg;

    // Transfer FSM states
    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_MEM,
        W_DONE
    } lll_state_e;

    // Largest legal word count on lll_wcnt
    localparam int unsigned LLL_MAX_WCNT = 4;

    // Widest data word the parity helper covers; narrower words are zero-padded
    localparam int unsigned LLL_PAR_MAX_W = 256;

    // Per-byte odd parity: bit i makes byte i plus the parity bit hold an odd number of ones
    function automatic logic [LLL_PAR_MAX_W/8-1:0] lll_odd_par(
        input logic [LLL_PAR_MAX_W-1:0] data
    );
        logic [LLL_PAR_MAX_W/8-1:0] p;
        p = '0;
        for (int i = 0; i < int'(LLL_PAR_MAX_W / 8); i++) begin
            p[i] = ~^data[8*i +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/lll_par_chk.sv
// Combinational per-byte odd-parity check of a data word against its parity bits.
module lll_par_chk
    import lll_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   data,
    input  logic [DATA_W/8-1:0] par,
    output logic                par_ok
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned MAXB   = LLL_PAR_MAX_W / 8;

    logic [LLL_PAR_MAX_W-1:0] data_ext;
    logic [MAXB-1:0]          par_calc;
    logic [MAXB-1:0]          par_ext;

    assign data_ext = LLL_PAR_MAX_W'(data);
    assign par_calc = lll_odd_par(data_ext);

    // Zero padding bytes always carry odd parity 1, so pad the supplied parity with ones
    always_comb begin
        par_ext             = '1;
        par_ext[NBYTES-1:0] = par;
    end

    assign par_ok = (par_calc == par_ext);

endmodule

// File: rtl/lll_write_resp.sv
// Responder end of the lll write interface: takes a 0..4 word burst, checks each
// word, writes it through the memory port and reports completion with an error flag.
// Optional feature macro: LLL_WR_PAR_CHK_EN enables per-byte odd-parity checking.
module lll_write_resp
    import lll_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WCNT = LLL_MAX_WCNT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                lll_start,
    input  logic [2:0]          lll_wcnt,
    input  logic [ADDR_W-1:0]   lll_addr,
    input  logic                lll_wvalid,
    output logic                lll_wready,
    input  logic [DATA_W-1:0]   lll_wdata,
    input  logic [DATA_W/8-1:0] lll_wpar,
    output logic                lll_busy,
    output logic                lll_done,
    output logic                lll_err,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    lll_state_e        state;
    logic [2:0]        remaining;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              par_ok;
    logic              wcnt_illegal;

    assign wcnt_illegal = int'(lll_wcnt) > int'(MAX_WCNT);

`ifdef LLL_WR_PAR_CHK_EN
    lll_par_chk #(
        .DATA_W (DATA_W)
    ) u_par_chk (
        .data   (lll_wdata),
        .par    (lll_wpar),
        .par_ok (par_ok)
    );
`else
    // Parity bits are accepted but ignored in this build
    logic unused_wpar;
    assign unused_wpar = ^lll_wpar;
    assign par_ok      = 1'b1;
`endif

    // The latched address/word drive the memory port directly, so they hold while req waits
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;

    // Transfer FSM with registered handshake, status and memory-request outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= W_IDLE;
            remaining  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            lll_wready <= 1'b0;
            lll_busy   <= 1'b0;
            lll_done   <= 1'b0;
            lll_err    <= 1'b0;
            mem_req    <= 1'b0;
        end else begin
            // done/err are single-cycle pulses raised only on entry to W_DONE
            lll_done <= 1'b0;
            lll_err  <= 1'b0;
            unique case (state)
                W_IDLE: begin
                    if (lll_start) begin
                        lll_busy <= 1'b1;
                        if (lll_wcnt == 3'd0 || wcnt_illegal) begin
                            state    <= W_DONE;
                            lll_done <= 1'b1;
                            lll_err  <= wcnt_illegal;
                        end else begin
                            state      <= W_DATA;
                            lll_wready <= 1'b1;
                            addr_q     <= lll_addr;
                            remaining  <= lll_wcnt;
                        end
                    end
                end
                W_DATA: begin
                    if (lll_wvalid) begin
                        lll_wready <= 1'b0;
                        if (par_ok) begin
                            data_q  <= lll_wdata;
                            state   <= W_MEM;
                            mem_req <= 1'b1;
                        end else begin
                            // Bad word aborts the burst; nothing further is written
                            state    <= W_DONE;
                            lll_done <= 1'b1;
                            lll_err  <= 1'b1;
                        end
                    end
                end
                W_MEM: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        remaining <= remaining - 3'd1;
                        addr_q    <= addr_q + ADDR_STEP;
                        if (remaining == 3'd1) begin
                            state    <= W_DONE;
                            lll_done <= 1'b1;
                        end else begin
                            state      <= W_DATA;
                            lll_wready <= 1'b1;
                        end
                    end
                end
                W_DONE: begin
                    state    <= W_IDLE;
                    lll_busy <= 1'b0;
                end
                default: begin
                    state      <= W_IDLE;
                    lll_busy   <= 1'b0;
                    lll_wready <= 1'b0;
                    mem_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lll_write_resp.sv
// Scoreboard bench for lll_write_resp: directed bursts push expected writes and
// completions; a negedge monitor pops and compares whatever the DUT presents.
module tb_lll_write_resp;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lll_start = 1'b0;
    logic [2:0]  lll_wcnt = '0;
    logic [31:0] lll_addr = '0;
    logic        lll_wvalid = 1'b0;
    logic        lll_wready;
    logic [31:0] lll_wdata = '0;
    logic [3:0]  lll_wpar = '0;
    logic        lll_busy;
    logic        lll_done;
    logic        lll_err;
    logic        mem_req;
    logic        mem_gnt = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    lll_write_resp #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WCNT (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .lll_start  (lll_start),
        .lll_wcnt   (lll_wcnt),
        .lll_addr   (lll_addr),
        .lll_wvalid (lll_wvalid),
        .lll_wready (lll_wready),
        .lll_wdata  (lll_wdata),
        .lll_wpar   (lll_wpar),
        .lll_busy   (lll_busy),
        .lll_done   (lll_done),
        .lll_err    (lll_err),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        bit err;
        int cyc;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    req_seen = 0;
    bit    done_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] odd_par(input logic [31:0] w);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ~^w[8*i +: 8];
        return p;
    endfunction

    // Monitor: compare every granted write and every completion against the queues
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_req) req_seen++;
            if (mem_req && mem_gnt) begin
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none expected",
                             mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write addr", 64'(mem_addr), 64'(e.a));
                    chk("write data", 64'(mem_wdata), 64'(e.d));
                end
            end
            if (done_prev) chk("err cleared after done", 64'(lll_err), 64'd0);
            if (lll_done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected done: err %0b at cycle %0d, none expected",
                             lll_err, cyc);
                end else begin
                    done_t e;
                    e = exp_done.pop_front();
                    chk("done err", 64'(lll_err), 64'(e.err));
                    chk("busy during done", 64'(lll_busy), 64'd1);
                    if (e.cyc >= 0) chk("done cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            done_prev = lll_done;
        end else begin
            done_prev = 1'b0;
        end
    end

    task automatic drive_word(input logic [31:0] w, input bit bad);
        lll_wdata = w;
        lll_wpar  = odd_par(w) ^ {3'b000, bad};
    endtask

    // One burst: queue expectations, drive start and words, optionally stall a grant
    task automatic run_xfer(input int wcnt, input logic [31:0] addr, input logic [31:0] base,
                            input int bad, input int stall_word, input bit chk_lat);
        int    nwr;
        int    lat;
        int    st;
        int    dc0;
        int    to;
        bit    err;
        bit    legal;
        done_t d;
        legal = (wcnt >= 1 && wcnt <= 4);
        err   = (wcnt > 4);
        nwr   = legal ? wcnt : 0;
`ifdef LLL_WR_PAR_CHK_EN
        if (legal && bad >= 0 && bad < wcnt) begin
            nwr = bad;
            err = 1'b1;
        end
`endif
        if (!legal) lat = 1;
        else if (err) lat = 2 + 2 * bad;
        else lat = 1 + 2 * wcnt;
        for (int i = 0; i < nwr; i++) exp_wr.push_back('{addr + 32'(4 * i), base + 32'(i)});

        @(posedge clk);
        #1;
        st        = cyc;
        dc0       = done_cnt;
        lll_start = 1'b1;
        lll_wcnt  = 3'(wcnt);
        lll_addr  = addr;
        d.err     = err;
        d.cyc     = chk_lat ? st + lat : -1;
        exp_done.push_back(d);
        drive_word(base, bad == 0);
        lll_wvalid = legal;
        @(posedge clk);
        #1;
        lll_start = 1'b0;

        if (legal) begin
            for (int k = 0; k < wcnt; k++) begin
                drive_word(base + 32'(k), bad == k);
                to = 0;
                do begin
                    @(negedge clk);
                    to++;
                end while (!lll_wready && to < 50);
                if (!lll_wready) begin
                    chk("wready timeout", 64'(lll_wready), 64'd1);
                    break;
                end
                @(posedge clk);
                #1;
                if (k == stall_word) begin
                    mem_gnt = 1'b0;
                    for (int i = 0; i < 5; i++) begin
                        @(negedge clk);
                        chk("stall req held", 64'(mem_req), 64'd1);
                        chk("stall addr stable", 64'(mem_addr), 64'(addr + 32'(4 * k)));
                        chk("stall data stable", 64'(mem_wdata), 64'(base + 32'(k)));
                        @(posedge clk);
                        #1;
                        lll_start = (i == 1);
                        lll_wcnt  = 3'd1;
                    end
                    lll_start = 1'b0;
                    mem_gnt   = 1'b1;
                end
`ifdef LLL_WR_PAR_CHK_EN
                if (k == bad) break;
`endif
            end
        end
        lll_wvalid = 1'b0;

        to = 0;
        while (done_cnt == dc0 && to < 60) begin
            @(negedge clk);
            to++;
        end
        if (done_cnt == dc0) chk("done timeout", 64'(done_cnt), 64'(dc0 + 1));
        @(negedge clk);
        chk("idle after done", 64'(lll_busy), 64'd0);
    endtask

    initial begin
        int r0;
        int dc;
        // Reset state
        #12;
        chk("reset busy", 64'(lll_busy), 64'd0);
        chk("reset wready", 64'(lll_wready), 64'd0);
        chk("reset mem_req", 64'(mem_req), 64'd0);
        chk("reset done", 64'(lll_done), 64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // wvalid with no transfer in progress is never accepted
        lll_wvalid = 1'b1;
        drive_word(32'hDEAD_BEEF, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("idle wready", 64'(lll_wready), 64'd0);
        end
        lll_wvalid = 1'b0;

        // Full burst, aligned address
        run_xfer(4, 32'h0000_0100, 32'h0000_00A0, -1, -1, 1'b1);
        // Address wrap
        run_xfer(2, 32'hFFFF_FFFC, 32'h0000_00B0, -1, -1, 1'b1);
        // Single word: done at cycle 3
        run_xfer(1, 32'h0000_0040, 32'h1234_5678, -1, -1, 1'b1);
        // Second word carries bad parity on byte 0
        run_xfer(3, 32'h0000_0200, 32'h0000_00C0, 1, -1, 1'b1);

        // Empty and illegal counts produce no memory requests
        r0 = req_seen;
        run_xfer(0, 32'h0000_0300, 32'h0, -1, -1, 1'b1);
        run_xfer(6, 32'h0000_0300, 32'h0, -1, -1, 1'b1);
        run_xfer(5, 32'h0000_0300, 32'h0, -1, -1, 1'b1);
        chk("no req for empty/illegal", 64'(req_seen), 64'(r0));

        // Grant stalled five cycles on word 1 with a stray start while busy
        run_xfer(2, 32'h0000_0400, 32'h0000_00D0, -1, 1, 1'b0);

        // Reset while waiting in W_MEM
        @(posedge clk);
        #1;
        mem_gnt    = 1'b0;
        lll_start  = 1'b1;
        lll_wcnt   = 3'd2;
        lll_addr   = 32'h0000_0500;
        lll_wvalid = 1'b1;
        drive_word(32'h0000_00E0, 1'b0);
        @(posedge clk);
        #1;
        lll_start = 1'b0;
        @(posedge clk);
        #1;
        lll_wvalid = 1'b0;
        @(negedge clk);
        chk("pre-reset mem_req", 64'(mem_req), 64'd1);
        dc = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset mem_req", 64'(mem_req), 64'd0);
        chk("async reset busy", 64'(lll_busy), 64'd0);
        chk("async reset mem_wdata", 64'(mem_wdata), 64'd0);
        mem_gnt = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no done after reset", 64'(done_cnt), 64'(dc));
        run_xfer(2, 32'h0000_0600, 32'h0000_00F0, -1, -1, 1'b1);

        repeat (3) @(negedge clk);
        chk("write queue drained", 64'(exp_wr.size()), 64'd0);
        chk("done queue drained", 64'(exp_done.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
